// File: rtl/scan_ctrl_pkg.sv
// Shared types and defaults for the scanline sequencer and related handshaking controllers.
package scan_ctrl_pkg;

  localparam int DW_INPUT_DEF  = 8;
  localparam int DW_ANGLE_DEF  = 8;
  localparam int DW_POINTS_DEF = 10;
  localparam int DW_LINES_DEF  = 8;
  localparam int ANGLE_MAX_DEF = 180;
  localparam int TIMEOUT_DEF   = 1023;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_RDY,
    PRESENT,
    ACK,
    GAP,
    FINISH
  } state_t;

  typedef struct packed {
    logic [DW_INPUT_DEF-1:0]  r_0;
    logic [DW_ANGLE_DEF-1:0]  angle_start;
    logic [DW_ANGLE_DEF-1:0]  angle_step;
    logic [DW_LINES_DEF-1:0]  num_lines;
    logic [DW_POINTS_DEF-1:0] num_points;
  } cfg_t;

endpackage

// File: rtl/scan_ctrl_timeout.sv
// Loadable down-counter; expired stays high once the count has run out to zero.
module scan_ctrl_timeout #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (enable && count != '0)
      count <= count - W'(1);
  end

  assign expired = (count == '0);

endmodule

// File: rtl/scanline_sequencer.sv
// Walks a frame of scanlines, stepping the increment-term calculator point by point
// and handing each result to a downstream consumer before acknowledging the calculator.
module scanline_sequencer
  import scan_ctrl_pkg::*;
#(
  parameter int DW_INPUT  = DW_INPUT_DEF,
  parameter int DW_ANGLE  = DW_ANGLE_DEF,
  parameter int DW_POINTS = DW_POINTS_DEF,
  parameter int DW_LINES  = DW_LINES_DEF,
  parameter int ANGLE_MAX = ANGLE_MAX_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DW_INPUT-1:0]  cfg_r_0,
  input  logic [DW_ANGLE-1:0]  cfg_angle_start,
  input  logic [DW_ANGLE-1:0]  cfg_angle_step,
  input  logic [DW_LINES-1:0]  cfg_num_lines,
  input  logic [DW_POINTS-1:0] cfg_num_points,
  output logic                 calc_configure,
  output logic                 calc_ack,
  output logic                 calc_final_scanpoint,
  output logic [DW_INPUT-1:0]  calc_r_0,
  output logic [DW_ANGLE-1:0]  calc_angle,
  input  logic                 calc_ready,
  output logic                 point_valid,
  input  logic                 point_ready,
  output logic [DW_POINTS-1:0] point_index,
  output logic [DW_LINES-1:0]  line_index,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DW_ANGLE:0] ANGLE_LIMIT = (DW_ANGLE + 1)'(ANGLE_MAX);

  state_t state, next_state;
  cfg_t   cfg_in;

  logic [DW_ANGLE-1:0]  step_q;
  logic [DW_LINES-1:0]  lines_q;
  logic [DW_POINTS-1:0] points_q;
  logic [DW_ANGLE:0]    angle_acc;
  logic [DW_ANGLE:0]    angle_next;
  logic abort_q, cfg_bad, last_point, last_line, angle_ovf, final_ack, tmo_expired;

  assign cfg_in = '{r_0: cfg_r_0, angle_start: cfg_angle_start, angle_step: cfg_angle_step,
                    num_lines: cfg_num_lines, num_points: cfg_num_points};

  assign cfg_bad    = (cfg_in.num_lines == '0) || (cfg_in.num_points == '0) ||
                      ({1'b0, cfg_in.angle_start} > ANGLE_LIMIT);
  assign last_point = (point_index == points_q - DW_POINTS'(1));
  assign last_line  = (line_index == lines_q - DW_LINES'(1));
  // angle_acc never exceeds ANGLE_MAX here, so the extra bit absorbs the sum without wrapping
  assign angle_next = angle_acc + {1'b0, step_q};
  assign angle_ovf  = (angle_next > ANGLE_LIMIT);
  assign final_ack  = last_point || abort_q;

  scan_ctrl_timeout #(.W(TW)) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .load       (state == LAUNCH),
    .load_value (TW'(TIMEOUT)),
    .enable     (state == WAIT_RDY),
    .expired    (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start && !cfg_bad) next_state = LAUNCH;
      LAUNCH:   next_state = WAIT_RDY;
      WAIT_RDY: begin
        if (calc_ready)
          next_state = PRESENT;
        else if (tmo_expired)
          next_state = IDLE;
      end
      PRESENT:  if (abort_q || point_ready) next_state = ACK;
      ACK:      next_state = final_ack ? GAP : WAIT_RDY;
      GAP: begin
        if (abort_q || (!last_line && angle_ovf))
          next_state = IDLE;
        else if (last_line)
          next_state = FINISH;
        else
          next_state = LAUNCH;
      end
      FINISH:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    calc_configure       = 1'b0;
    calc_ack             = 1'b0;
    calc_final_scanpoint = 1'b0;
    point_valid          = 1'b0;
    done                 = 1'b0;
    err                  = 1'b0;
    busy                 = (state != IDLE);
    case (state)
      IDLE:     err = start && cfg_bad && !rst;
      LAUNCH:   calc_configure = 1'b1;
      WAIT_RDY: err = !calc_ready && tmo_expired;
      PRESENT:  point_valid = !abort_q;
      ACK: begin
        calc_ack             = 1'b1;
        calc_final_scanpoint = final_ack;
      end
      GAP:      err = !abort_q && !last_line && angle_ovf;
      FINISH:   done = 1'b1;
      default:  ;
    endcase
  end

  // Frame registers; an abort is only remembered while a frame is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q      <= '0;
      lines_q     <= '0;
      points_q    <= '0;
      angle_acc   <= '0;
      calc_r_0    <= '0;
      calc_angle  <= '0;
      point_index <= '0;
      line_index  <= '0;
      abort_q     <= 1'b0;
    end else begin
      if (state == IDLE)
        abort_q <= 1'b0;
      else if (abort)
        abort_q <= 1'b1;

      case (state)
        IDLE: begin
          if (start && !cfg_bad) begin
            step_q      <= cfg_in.angle_step;
            lines_q     <= cfg_in.num_lines;
            points_q    <= cfg_in.num_points;
            angle_acc   <= {1'b0, cfg_in.angle_start};
            calc_r_0    <= cfg_in.r_0;
            calc_angle  <= cfg_in.angle_start;
            point_index <= '0;
            line_index  <= '0;
          end
        end
        ACK: begin
          if (!final_ack)
            point_index <= point_index + DW_POINTS'(1);
        end
        GAP: begin
          if (!abort_q && !last_line && !angle_ovf) begin
            line_index  <= line_index + DW_LINES'(1);
            point_index <= '0;
            angle_acc   <= angle_next;
            calc_angle  <= angle_next[DW_ANGLE-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scanline_sequencer.sv
// Randomized bench for scanline_sequencer: a frame-level model predicts configure angles,
// delivered points, ack finality and done/err pulses, compared against a negedge monitor.
module tb_scanline_sequencer;

  localparam int TIMEOUT = 1023;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort;
  logic [7:0] cfg_r_0 = '0, cfg_angle_start = '0, cfg_angle_step = '0, cfg_num_lines = '0;
  logic [9:0] cfg_num_points = '0;
  logic       calc_configure, calc_ack, calc_final_scanpoint, calc_ready;
  logic [7:0] calc_r_0, calc_angle, line_index;
  logic       point_valid, point_ready, busy, done, err;
  logic [9:0] point_index;

  scanline_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .abort                (abort),
    .cfg_r_0              (cfg_r_0),
    .cfg_angle_start      (cfg_angle_start),
    .cfg_angle_step       (cfg_angle_step),
    .cfg_num_lines        (cfg_num_lines),
    .cfg_num_points       (cfg_num_points),
    .calc_configure       (calc_configure),
    .calc_ack             (calc_ack),
    .calc_final_scanpoint (calc_final_scanpoint),
    .calc_r_0             (calc_r_0),
    .calc_angle           (calc_angle),
    .calc_ready           (calc_ready),
    .point_valid          (point_valid),
    .point_ready          (point_ready),
    .point_index          (point_index),
    .line_index           (line_index),
    .busy                 (busy),
    .done                 (done),
    .err                  (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int exp_angles[$], exp_hs[$], exp_acks[$];
  int got_angles[$], got_hs[$], got_acks[$];
  int exp_done, exp_err, done_cnt, err_cnt, stall_cnt, stall_left;
  int cur_r0, cyc, last_cfg_cyc, last_err_cyc, last_idle_cyc;
  int abort_line = -1, abort_pt = 0;
  bit abort_sent = 0, calc_never = 0;
  int ready_mode = 0;
  bit prev_valid = 0, prev_hs = 0, prev_busy = 0, prev_rst = 1;
  logic [9:0] prev_idx = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Frame-level prediction: angles per line, every delivered point, ack finality, end pulse
  task automatic build_expect(input int as, input int st, input int nl, input int np);
    exp_angles.delete(); exp_hs.delete(); exp_acks.delete();
    exp_done = 0;
    exp_err  = 0;
    if (nl == 0 || np == 0 || as > 180) begin
      exp_err = 1;
      return;
    end
    for (int l = 0; l < nl; l++) begin
      int ang;
      ang = as + l * st;
      if (ang > 180) begin
        exp_err = 1;
        return;
      end
      exp_angles.push_back(ang);
      if (calc_never) begin
        exp_err = 1;
        return;
      end
      for (int k = 0; k < np; k++) begin
        if (l == abort_line && k == abort_pt) begin
          exp_acks.push_back(1);
          return;
        end
        exp_hs.push_back(l * 1024 + k);
        exp_acks.push_back(k == np - 1 ? 1 : 0);
      end
    end
    exp_done = 1;
  endtask

  // Calculator stand-in: result appears a few cycles after configure or a non-final ack
  initial begin
    int delay;
    bit pending;
    calc_ready = 1'b0;
    delay = 0;
    pending = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        calc_ready = 1'b0;
        pending = 0;
      end else if (calc_ack) begin
        calc_ready = 1'b0;
        pending = !calc_final_scanpoint;
        delay = $urandom_range(1, 3);
      end else if (calc_configure) begin
        calc_ready = 1'b0;
        pending = 1;
        delay = $urandom_range(0, 3);
      end else if (pending) begin
        if (delay == 0) begin
          calc_ready = !calc_never;
          pending = 0;
        end else begin
          delay--;
        end
      end
    end
  end

  initial begin
    point_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: point_ready = 1'b1;
        1: point_ready = ($urandom_range(0, 99) < 60);
        default: begin
          if (point_valid && line_index == 0 && point_index == 2 && stall_left > 0) begin
            point_ready = 1'b0;
            stall_left--;
          end else begin
            point_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Fires one abort while the chosen point is still waiting on the calculator
  initial begin
    abort = 1'b0;
    forever begin
      @(posedge clk); #1;
      abort = 1'b0;
      if (abort_line >= 0 && !abort_sent && busy && int'(line_index) == abort_line &&
          int'(point_index) == abort_pt && !point_valid && !calc_ack && !calc_configure && !calc_ready) begin
        abort = 1'b1;
        abort_sent = 1;
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (calc_configure) begin
        got_angles.push_back(int'(calc_angle));
        last_cfg_cyc = cyc;
        checkOutput("calc_r_0", calc_r_0, cur_r0);
      end
      if (point_valid && point_ready)
        got_hs.push_back(int'(line_index) * 1024 + int'(point_index));
      if (point_valid && !point_ready)
        stall_cnt++;
      if (calc_ack) begin
        got_acks.push_back(int'(calc_final_scanpoint));
        if (!abort_sent)
          checkOutput("ack_after_hs", prev_hs, 1);
      end
      if (done)
        done_cnt++;
      if (err) begin
        err_cnt++;
        last_err_cyc = cyc;
      end
      if (prev_valid && !prev_hs && !prev_rst && !abort_sent) begin
        checkOutput("valid_hold", point_valid, 1);
        checkOutput("index_hold", point_index, prev_idx);
      end
      if (prev_busy && !busy)
        last_idle_cyc = cyc;
    end
    prev_valid = point_valid;
    prev_hs    = point_valid && point_ready;
    prev_idx   = point_index;
    prev_busy  = busy;
    prev_rst   = rst;
  end

  task automatic applyStimulus(input int r0, input int as, input int st, input int nl, input int np);
    bit bad;
    int n;
    build_expect(as, st, nl, np);
    got_angles.delete(); got_hs.delete(); got_acks.delete();
    done_cnt = 0;
    err_cnt = 0;
    stall_cnt = 0;
    abort_sent = 0;
    cur_r0 = r0;
    bad = (nl == 0) || (np == 0) || (as > 180);
    @(posedge clk); #1;
    cfg_r_0 = 8'(r0);
    cfg_angle_start = 8'(as);
    cfg_angle_step = 8'(st);
    cfg_num_lines = 8'(nl);
    cfg_num_points = 10'(np);
    start = 1'b1;
    @(negedge clk);
    checkOutput("err_on_start", err, bad);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("cfg_latency", calc_configure, !bad);
    n = 0;
    while (busy && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("frame_end", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("n_configure", got_angles.size(), exp_angles.size());
    for (int i = 0; i < got_angles.size() && i < exp_angles.size(); i++)
      checkOutput("calc_angle", got_angles[i], exp_angles[i]);
    checkOutput("n_handshake", got_hs.size(), exp_hs.size());
    for (int i = 0; i < got_hs.size() && i < exp_hs.size(); i++)
      checkOutput("handshake_pos", got_hs[i], exp_hs[i]);
    checkOutput("n_ack", got_acks.size(), exp_acks.size());
    for (int i = 0; i < got_acks.size() && i < exp_acks.size(); i++)
      checkOutput("ack_final", got_acks[i], exp_acks[i]);
    checkOutput("done_count", done_cnt, exp_done);
    checkOutput("err_count", err_cnt, exp_err);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_outputs",
                {busy, point_valid, calc_configure, calc_ack, calc_final_scanpoint, done, err, calc_r_0, calc_angle}, 0);
    checkOutput("reset_indices", {line_index, point_index}, 0);

    ready_mode = 0;
    applyStimulus(20, 60, 10, 3, 4);

    ready_mode = 2;
    stall_left = 5;
    applyStimulus(20, 60, 10, 3, 4);
    checkOutput("stall_cycles", stall_cnt, 5);
    ready_mode = 0;

    applyStimulus(20, 60, 10, 3, 0);
    applyStimulus(20, 60, 10, 0, 4);
    applyStimulus(5, 181, 1, 2, 2);
    applyStimulus(5, 170, 20, 2, 3);

    abort_line = 1;
    abort_pt = 2;
    applyStimulus(20, 60, 10, 3, 4);
    abort_line = -1;

    calc_never = 1;
    applyStimulus(7, 30, 5, 2, 2);
    calc_never = 0;
    checkOutput("timeout_delay", last_err_cyc - last_cfg_cyc, TIMEOUT + 1);
    checkOutput("timeout_idle", last_idle_cyc - last_err_cyc, 1);

    got_acks.delete();
    cur_r0 = 33;
    @(posedge clk); #1;
    cfg_r_0 = 8'd33;
    cfg_angle_start = 8'd45;
    cfg_angle_step = 8'd5;
    cfg_num_lines = 8'd2;
    cfg_num_points = 10'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!point_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("reach_present", point_valid, 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_mid_outputs",
                {busy, point_valid, calc_configure, calc_ack, calc_final_scanpoint, done, err, calc_r_0, calc_angle}, 0);
    checkOutput("rst_mid_indices", {line_index, point_index}, 0);
    checkOutput("rst_no_ack", got_acks.size(), 0);
    applyStimulus(20, 60, 10, 3, 4);

    ready_mode = 1;
    for (int t = 0; t < 12; t++)
      applyStimulus($urandom_range(0, 255), $urandom_range(0, 200), $urandom_range(0, 60),
                    $urandom_range(0, 4), $urandom_range(0, 5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
